imem_arbiter: RTL and testbench

- Sequences and shares the byte-wide instruction memory between two requesters.
- The instruction-fetch requester issues word reads. The memory returns four bytes, and the block assembles them big-endian into one 32-bit instruction.
- The boot loader issues byte writes.
- Sits between pc/if and a byte-wide synchronous-read memory array. It replaces the direct combinational word read with a handshaked, arbitrated transaction engine.

---
 rtl/imem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a byte-wide synchronous-read instruction memory
// between the instruction-fetch path (word reads, big-endian assembly) and
// the boot loader (byte writes), with tie-only round-robin arbitration.
module imem_arbiter #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     PART_ADDR_WIDTH = 16,
  parameter logic [XLEN-1:0] MEM_OFFSET      = 32'h8000_0000,
  parameter int unsigned     MEM_SIZE        = 65536
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       boot_mode_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [XLEN-1:0]            fetch_addr_i,
  output logic                       inst_valid_o,
  output logic [XLEN-1:0]            inst_o,
  output logic [XLEN-1:0]            pc_o,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic [XLEN-1:0]            ld_addr_i,
  input  logic [7:0]                 ld_data_i,
  output logic                       ld_err_o,
  output logic                       mem_re_o,
  output logic                       mem_we_o,
  output logic [PART_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]                 mem_wdata_o,
  input  logic [7:0]                 mem_rdata_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WR    = 2'd3;

  localparam logic GRANT_FETCH  = 1'b0;
  localparam logic GRANT_LOADER = 1'b1;

  // One bit wider than XLEN so OFFSET+SIZE cannot overflow the compare.
  localparam logic [XLEN:0] MEM_END = {1'b0, MEM_OFFSET} + (XLEN+1)'(MEM_SIZE);

  logic [1:0]                 state_q;
  logic [1:0]                 cnt_q;
  logic                       last_grant_q;
  logic [PART_ADDR_WIDTH-1:0] base_q;
  logic [XLEN-1:0]            pc_q;
  logic [23:0]                shift_q;
  logic [PART_ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]                 wdata_q;
  logic                       wr_ok_q;
  logic                       inst_valid_q;
  logic [XLEN-1:0]            inst_q;
  logic [XLEN-1:0]            pc_out_q;

  logic idle;
  logic fetch_eligible;
  logic fetch_fire;
  logic ld_fire;
  logic ld_in_range;

  // Readies are gated by rst_ni so they read 0 while reset is held.
  assign idle           = rst_ni && (state_q == IDLE);
  assign fetch_eligible = !boot_mode_i && !flush_i;
  assign fetch_ready_o  = idle && fetch_eligible &&
                          !(ld_valid_i && (last_grant_q == GRANT_FETCH));
  assign ld_ready_o     = idle &&
                          !(fetch_valid_i && fetch_eligible && (last_grant_q == GRANT_LOADER));
  assign fetch_fire     = fetch_valid_i && fetch_ready_o;
  assign ld_fire        = ld_valid_i && ld_ready_o;

  assign ld_in_range = ({1'b0, ld_addr_i} >= {1'b0, MEM_OFFSET}) &&
                       ({1'b0, ld_addr_i} <  MEM_END);

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;

  // Transaction sequencer: grant, read/write cycles, byte assembly, response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: datapath registers are reset as well as control, so every
      // output reads 0 during reset and nothing stale leaks afterwards.
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= GRANT_FETCH;
      base_q       <= '0;
      pc_q         <= '0;
      shift_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wr_ok_q      <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      pc_out_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would create order-dependent state.
      inst_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_fire) begin
            state_q      <= FETCH;
            cnt_q        <= 2'd0;
            base_q       <= {fetch_addr_i[PART_ADDR_WIDTH-1:2], 2'b00};
            pc_q         <= fetch_addr_i;
            last_grant_q <= GRANT_FETCH;
          end else if (ld_fire) begin
            state_q      <= WR;
            waddr_q      <= ld_addr_i[PART_ADDR_WIDTH-1:0] - MEM_OFFSET[PART_ADDR_WIDTH-1:0];
            wdata_q      <= ld_data_i;
            wr_ok_q      <= ld_in_range;
            last_grant_q <= GRANT_LOADER;
          end
        end
        FETCH: begin
          // Read data lags the strobe by one cycle; bytes 0..2 arrive here.
          if (cnt_q != 2'd0) shift_q <= {shift_q[15:0], mem_rdata_i};
          cnt_q <= cnt_q + 2'd1;
          if (flush_i)              state_q <= IDLE;
          else if (cnt_q == 2'd3)   state_q <= WAIT;
        end
        WAIT: begin
          // Byte 3 arrives now and completes the big-endian word.
          state_q <= IDLE;
          if (!flush_i) begin
            inst_valid_q <= 1'b1;
            inst_q       <= XLEN'({shift_q, mem_rdata_i});
            pc_out_q     <= pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-side strobes decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    ld_err_o    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_re_o   = 1'b1;
        mem_addr_o = base_q + PART_ADDR_WIDTH'(cnt_q);
      end
      WR: begin
        mem_we_o = wr_ok_q;
        ld_err_o = !wr_ok_q;
        if (wr_ok_q) begin
          mem_addr_o  = waddr_q;
          mem_wdata_o = wdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a byte-memory model and a response
// scoreboard fed at fetch-accept time.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        boot_mode_i, flush_i;
  logic        fetch_valid_i, fetch_ready_o;
  logic [31:0] fetch_addr_i;
  logic        inst_valid_o;
  logic [31:0] inst_o, pc_o;
  logic        ld_valid_i, ld_ready_o;
  logic [31:0] ld_addr_i;
  logic [7:0]  ld_data_i;
  logic        ld_err_o;
  logic        mem_re_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata;

  imem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .boot_mode_i(boot_mode_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_addr_i(fetch_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .ld_err_o(ld_err_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read byte memory driven by the DUT's strobes.
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata <= mem[mem_addr_o];
  end

  always @(negedge rst_ni) exp_q.delete();

  // Monitor: track accepted requests and score responses.
  always @(negedge clk) begin
    #2;
    if (rst_ni) begin
      check("re_we_exclusive", {31'b0, mem_re_o && mem_we_o}, 32'd0);
      if (ld_valid_i && ld_ready_o && ld_addr_i[31:16] == 16'h8000)
        ref_mem[ld_addr_i[15:0]] = ld_data_i;
      if (fetch_valid_i && fetch_ready_o) begin
        exp_t e;
        logic [15:0] b;
        b = {fetch_addr_i[15:2], 2'b00};
        e.inst = {ref_mem[b], ref_mem[b + 16'd1], ref_mem[b + 16'd2], ref_mem[b + 16'd3]};
        e.pc   = fetch_addr_i;
        e.cyc  = cyc + 6;
        exp_q.push_back(e);
      end
      if (inst_valid_o) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {31'b0, inst_valid_o}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_inst", inst_o, e.inst);
          check("sb_pc", pc_o, e.pc);
          check("sb_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic ld_write(input logic [31:0] addr, input logic [7:0] data, input bit ok);
    @(negedge clk);
    ld_valid_i = 1'b1; ld_addr_i = addr; ld_data_i = data;
    #1;
    check("ld_ready", {31'b0, ld_ready_o}, 32'd1);
    @(negedge clk);
    ld_valid_i = 1'b0;
    #1;
    check("ld_we", {31'b0, mem_we_o}, {31'b0, ok});
    check("ld_err", {31'b0, ld_err_o}, {31'b0, !ok});
    if (ok) begin
      check("ld_waddr", {16'b0, mem_addr_o}, {16'b0, addr[15:0]});
      check("ld_wdata", {24'b0, mem_wdata_o}, {24'b0, data});
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_inst, input bit boot_mid);
    logic [15:0] b;
    b = {addr[15:2], 2'b00};
    @(negedge clk);
    fetch_valid_i = 1'b1; fetch_addr_i = addr;
    #1;
    check("f_ready", {31'b0, fetch_ready_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fetch_valid_i = 1'b0;
      if (boot_mid && k == 1) boot_mode_i = 1'b1;
      #1;
      check("f_re", {31'b0, mem_re_o}, 32'd1);
      check("f_addr", {16'b0, mem_addr_o}, {16'b0, b + 16'(k)});
      check("f_we", {31'b0, mem_we_o}, 32'd0);
    end
    @(negedge clk); #1;
    check("f_wait_re", {31'b0, mem_re_o}, 32'd0);
    check("f_wait_valid", {31'b0, inst_valid_o}, 32'd0);
    @(negedge clk); #1;
    check("f_valid", {31'b0, inst_valid_o}, 32'd1);
    check("f_inst", inst_o, exp_inst);
    check("f_pc", pc_o, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngrant;
    bit grants [0:3];   // 1 = loader, 0 = fetch

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_ni = 1'b0; boot_mode_i = 1'b0; flush_i = 1'b0;
    fetch_valid_i = 1'b0; fetch_addr_i = '0;
    ld_valid_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;

    // Reset state, with both requesters asserting.
    repeat (2) @(negedge clk);
    fetch_valid_i = 1'b1; ld_valid_i = 1'b1; ld_addr_i = 32'h8000_0000;
    #1;
    check("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
    check("rst_ld_ready", {31'b0, ld_ready_o}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_ld_err", {31'b0, ld_err_o}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re_o}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr_o}, 32'd0);
    check("rst_mem_wdata", {24'b0, mem_wdata_o}, 32'd0);
    fetch_valid_i = 1'b0; ld_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Preload and loader range boundaries.
    ld_write(32'h8000_0010, 8'h13, 1'b1);
    ld_write(32'h8000_0011, 8'h05, 1'b1);
    ld_write(32'h8000_0012, 8'h00, 1'b1);
    ld_write(32'h8000_0013, 8'h00, 1'b1);
    ld_write(32'h8000_0004, 8'hAB, 1'b1);
    ld_write(32'h7FFF_FFFF, 8'h55, 1'b0);
    ld_write(32'h8001_0000, 8'h66, 1'b0);
    ld_write(32'h8000_FFFF, 8'h77, 1'b1);

    // Fetch byte order; then a fetch during which boot mode rises.
    do_fetch(32'h8000_0012, 32'h1305_0000, 1'b0);
    do_fetch(32'h8000_0004, 32'hAB00_0000, 1'b1);

    // Boot mode: fetch never granted, loader writes every 2 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0010;
      if (i % 2 == 0) begin
        ld_valid_i = 1'b1; ld_addr_i = 32'h8000_0200 + 32'(i / 2); ld_data_i = 8'(i);
      end else begin
        ld_valid_i = 1'b0;
      end
      #1;
      check("boot_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
      if (i % 2 == 0) check("boot_ld_ready", {31'b0, ld_ready_o}, 32'd1);
      else begin
        check("boot_we", {31'b0, mem_we_o}, 32'd1);
        check("boot_waddr", {16'b0, mem_addr_o}, 32'h200 + 32'(i / 2));
      end
    end

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    boot_mode_i = 1'b0; ld_valid_i = 1'b0; flush_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0010;
    #1;
    check("flush_idle_ready", {31'b0, fetch_ready_o}, 32'd0);
    // Accept, then flush in cycle 3.
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_accept", {31'b0, fetch_ready_o}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      fetch_valid_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_c3_re", {31'b0, mem_re_o}, 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_c4_re", {31'b0, mem_re_o}, 32'd0);
    check("flush_c4_idle", {31'b0, fetch_ready_o}, 32'd1);
    check("flush_sb_depth", exp_q.size(), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (6) begin
      @(negedge clk); #1;
      check("flush_no_resp", {31'b0, inst_valid_o}, 32'd0);
    end
    do_fetch(32'h8000_0013, 32'h1305_0000, 1'b0);

    // Async reset in cycle 2 of a fetch.
    @(negedge clk);
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0004;
    #1;
    check("ar_accept", {31'b0, fetch_ready_o}, 32'd1);
    @(negedge clk);
    fetch_valid_i = 1'b0;
    @(negedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    check("ar_mem_re", {31'b0, mem_re_o}, 32'd0);
    check("ar_mem_addr", {16'b0, mem_addr_o}, 32'd0);
    check("ar_inst", inst_o, 32'd0);
    check("ar_pc", pc_o, 32'd0);
    check("ar_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0010;
    ld_valid_i = 1'b1; ld_addr_i = 32'h8000_0300; ld_data_i = 8'hC3;
    #1;
    check("ar_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
    check("ar_ld_ready", {31'b0, ld_ready_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Arbitration with both requesters held: loader first, then alternate.
    ngrant = 0;
    for (int c = 0; c < 60 && ngrant < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < 8) check("ar_no_resp", {31'b0, inst_valid_o}, 32'd0);
      if (ld_valid_i && ld_ready_o) begin
        grants[ngrant] = 1'b1; ngrant++;
      end else if (fetch_valid_i && fetch_ready_o) begin
        grants[ngrant] = 1'b0; ngrant++;
      end
    end
    check("arb_count", ngrant, 32'd4);
    check("arb_g0", {31'b0, grants[0]}, 32'd1);
    check("arb_g1", {31'b0, grants[1]}, 32'd0);
    check("arb_g2", {31'b0, grants[2]}, 32'd1);
    check("arb_g3", {31'b0, grants[3]}, 32'd0);
    @(negedge clk);
    fetch_valid_i = 1'b0; ld_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
